// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state type and baud divisor helper
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = 10;
  typedef enum logic {IDLE, SEND} state_e;
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-producer handshake and serial pin of the UART transmitter
interface uart_tx_if;
  import uart_pkg::*;
  logic [DATA_BITS-1:0] data_in;
  logic po_flag;
  logic data_tx;
  logic end_flag;
  modport master (output data_in, po_flag, input data_tx, end_flag);
  modport slave (input data_in, po_flag, output data_tx, end_flag);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: enable-gated 0..N-1 bit-period counter with wrap pulse
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int N = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic wrap_o
);
  localparam int W = $clog2(N);
  logic [W-1:0] cnt_q;
  assign wrap_o = en_i && cnt_q == W'(N - 1);
  // count while enabled, restart at the wrap, hold at zero when disabled
  always_ff @(posedge clk)
    cnt_q <= (rst || !en_i || wrap_o) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-N-1 serial transmitter, one byte in flight, one-cycle end_flag
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200
) (
  input logic s_clk,
  input logic s_rst,
  uart_tx_if.slave bus
);
  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  state_e state_q;
  logic [3:0] bit_q;
  logic [DATA_BITS-1:0] sh_q;
  logic data_tx_q, done_q, end_flag_q;
  logic wrap, exit_d, line_d;
  uart_baud_cnt #(.N(BIT_CYCLES)) u_baud (
    .clk   (s_clk),
    .rst   (s_rst),
    .en_i  (state_q == SEND),
    .wrap_o(wrap)
  );
  assign exit_d = state_q == SEND && wrap && bit_q == 4'(FRAME_BITS - 1);
  assign line_d = (state_q == IDLE || bit_q == 4'(FRAME_BITS - 1)) ? 1'b1 :
                  bit_q == '0 ? 1'b0 : sh_q[0];
  assign bus.data_tx = data_tx_q;
  assign bus.end_flag = end_flag_q;
  // FSM, bit counter and shifter; pin and end pulse lag the state by one flop
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q <= IDLE;
      bit_q <= '0;
      sh_q <= '0;
      data_tx_q <= 1'b1;
      done_q <= 1'b0;
      end_flag_q <= 1'b0;
    end else begin
      data_tx_q <= line_d;
      done_q <= exit_d;
      end_flag_q <= done_q;
      if (state_q == IDLE) begin
        if (bus.po_flag) begin
          sh_q <= bus.data_in;
          bit_q <= '0;
          state_q <= SEND;
        end
      end else if (wrap) begin
        bit_q <= exit_d ? '0 : bit_q + 1'b1;
        if (bit_q != '0) sh_q <= sh_q >> 1;
        if (exit_d) state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random frames checked against a frame-timing model
module tb_uart_tx;
  localparam int BC = 50_000_000 / 115_200;
  localparam int FRAME = 10 * BC;
  localparam int NONE = -1_000_000;
  logic s_clk = 1'b0;
  logic s_rst = 1'b1;
  uart_tx_if bus ();
  uart_tx dut (.s_clk(s_clk), .s_rst(s_rst), .bus(bus));
  always #5 s_clk = ~s_clk;
  int checks = 0, errors = 0, cyc = 0, acc = NONE, last_end = NONE, end_edge = NONE;
  int bad_line, bad_end, bad_period, ends, run_len, low_run;
  logic [7:0] fb;
  logic [9:0] obs;
  logic prev = 1'bx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    bad_line = 0; bad_end = 0; bad_period = 0; ends = 0;
    last_end = NONE; end_edge = NONE; obs = 'x;
  endtask

  // One clock: advance the model at the edge, then observe 1 time unit later.
  // A frame accepted at edge acc occupies edges acc+1 .. acc+10*BC on the line.
  task automatic tick();
    logic exp_line, exp_end;
    int k;
    @(posedge s_clk);
    cyc++;
    exp_end = !s_rst && cyc == acc + 1 + FRAME;
    if (s_rst) acc = NONE;
    else if (bus.po_flag === 1'b1 && cyc >= acc + 1 + FRAME) begin
      acc = cyc;
      fb = bus.data_in;
    end
    k = cyc - acc - 1;
    exp_line = (k < 0 || k >= FRAME) ? 1'b1 :
               (k / BC == 0) ? 1'b0 : (k / BC == 9) ? 1'b1 : fb[k / BC - 1];
    #1;
    if (bus.data_tx !== exp_line) bad_line++;
    if (bus.end_flag !== exp_end) bad_end++;
    if (bus.end_flag === 1'b1) begin
      ends++;
      if (last_end != NONE && cyc - last_end != FRAME + 1) bad_period++;
      last_end = cyc;
      end_edge = cyc;
    end
    if (bus.data_tx === prev) run_len++;
    else begin
      if (prev === 1'b0) low_run = run_len;
      prev = bus.data_tx;
      run_len = 1;
    end
    if (k >= 0 && k < FRAME && k % BC == BC / 2) obs[k / BC] = bus.data_tx;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Send one byte with po_flag held for `hold` clocks; data_in becomes nd afterwards.
  task automatic send(input logic [7:0] b, input int hold, input logic [7:0] nd, input string tag);
    clr();
    bus.data_in = b;
    bus.po_flag = 1'b1;
    for (int i = 0; i < FRAME + 4; i++) begin
      tick();
      if (i == hold - 1) begin
        bus.po_flag = 1'b0;
        bus.data_in = nd;
      end
    end
    chk($sformatf("%s_line", tag), bad_line, 0);
    chk($sformatf("%s_end", tag), bad_end, 0);
    chk($sformatf("%s_ends", tag), ends, 1);
    chk($sformatf("%s_end_delay", tag), end_edge - acc, FRAME + 1);
    chk($sformatf("%s_bits", tag), obs, {1'b1, b, 1'b0});
  endtask

  initial begin
    logic [7:0] r;
    bus.po_flag = 1'b0;
    bus.data_in = 8'h00;
    clr();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_tx", bus.data_tx, 1);
      chk("rst_end", bus.end_flag, 0);
    end
    s_rst = 1'b0;
    clr();
    run(5);
    chk("idle_tx", bus.data_tx, 1);
    chk("idle_line", bad_line, 0);
    chk("idle_end", bad_end, 0);

    send(8'hF5, 1, 8'h00, "f5");
    chk("f5_pattern", obs, 10'b1111101010);

    clr();
    bus.data_in = 8'hF5;
    bus.po_flag = 1'b1;
    run(50_000);
    chk("held_ends", ends, 11);
    chk("held_period", bad_period, 0);
    chk("held_line", bad_line, 0);
    chk("held_end", bad_end, 0);
    bus.po_flag = 1'b0;
    run(2200);
    chk("held_drain_line", bad_line, 0);
    chk("held_drain_ends", ends, 12);

    clr();
    bus.data_in = 8'hF5;
    bus.po_flag = 1'b1;
    tick();
    bus.po_flag = 1'b0;
    run(2000);
    bus.data_in = 8'h0F;
    bus.po_flag = 1'b1;
    tick();
    bus.po_flag = 1'b0;
    run(FRAME + 2 - 2001);
    chk("mid_bits", obs, 10'b1111101010);
    chk("mid_ends", ends, 1);
    chk("mid_line", bad_line, 0);
    chk("mid_end", bad_end, 0);

    clr();
    r = 8'($urandom_range(0, 255));
    bus.data_in = r;
    bus.po_flag = 1'b1;
    tick();
    bus.po_flag = 1'b0;
    run(4 * BC + 100);
    chk("pre_rst_bit3", bus.data_tx, r[3]);
    s_rst = 1'b1;
    tick();
    chk("mid_rst_tx", bus.data_tx, 1);
    chk("mid_rst_end", bus.end_flag, 0);
    s_rst = 1'b0;
    run(FRAME);
    chk("aborted_ends", ends, 0);
    chk("aborted_line", bad_line, 0);
    send(8'($urandom_range(0, 255)), 1, 8'h00, "after_rst");

    send(8'h00, 1, 8'hFF, "zero");
    chk("zero_low_run", low_run, 9 * BC);
    send(8'hFF, 1, 8'h00, "ones");
    chk("ones_low_run", low_run, BC);

    send(8'($urandom_range(0, 255)), $urandom_range(1, 20), 8'($urandom_range(0, 255)), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
